// File: rtl/act_lut_arbiter_if.sv
// rtl/act_lut_arbiter_if.sv - request/result handshake bundle for act_lut_arbiter
// master = requesters plus result sink, slave = arbiter.
interface act_lut_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) ();
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [8*N_REQ-1:0] req_data;
  logic               res_valid;
  logic               res_ready;
  logic [7:0]         res_data;
  logic [ID_W-1:0]    res_id;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/act_lut_arbiter.sv
// rtl/act_lut_arbiter.sv - round-robin arbiter sharing one interpolating activation LUT
// Optional ACT_LUT_STAT_EN adds a 16-bit lookup_count of delivered results.
module act_lut_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  act_lut_arbiter_if.slave    bus,
  output logic [3:0]          lut_address,
  input  logic [7:0]          lut_base,
  input  logic [7:0]          lut_next
`ifdef ACT_LUT_STAT_EN
  ,
  output logic [15:0]         lookup_count
`endif
);

  typedef enum logic [1:0] {IDLE, LOOKUP, OUTPUT} state_t;

  state_t             state;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    cur_id;
  logic [3:0]         x_frac;
  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    cand;
  logic [7:0]         grant_data;
  logic signed [8:0]  diff;
  logic signed [13:0] prod;
  logic [7:0]         res_next;

  // Scan from last_grant+1 so the previous winner gets lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % N_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && grant_found)
      bus.req_ready[grant_id] = 1'b1;
  end

  assign grant_data = bus.req_data[int'(grant_id)*8 +: 8];

  always_comb begin
    diff     = $signed({lut_next[7], lut_next}) - $signed({lut_base[7], lut_base});
    prod     = diff * $signed({1'b0, x_frac});
    res_next = 8'($signed({{6{lut_base[7]}}, lut_base}) + (prod >>> 4));
  end

  // The latched x lives split: high nibble in lut_address, low nibble in x_frac.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= ID_W'(N_REQ - 1);
      cur_id        <= '0;
      x_frac        <= '0;
      lut_address   <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            last_grant  <= grant_id;
            cur_id      <= grant_id;
            x_frac      <= grant_data[3:0];
            lut_address <= grant_data[7:4];
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          bus.res_data  <= res_next;
          bus.res_id    <= cur_id;
          bus.res_valid <= 1'b1;
          state         <= OUTPUT;
        end
        OUTPUT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ACT_LUT_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lookup_count <= '0;
    else if (bus.res_valid && bus.res_ready)
      lookup_count <= lookup_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_act_lut_arbiter.sv
// tb/tb_act_lut_arbiter.sv - scoreboard bench for act_lut_arbiter
// LUT holds 0,16,..,112 at 0..7, 0 at 8..15, next clamps at 7 and wraps 15->0.
module tb_act_lut_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  act_lut_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();
  logic [3:0] lut_address;
  logic [7:0] lut_base;
  logic [7:0] lut_next;
`ifdef ACT_LUT_STAT_EN
  logic [15:0] lookup_count;
`endif

  act_lut_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .lut_address (lut_address),
    .lut_base    (lut_base),
    .lut_next    (lut_next)
`ifdef ACT_LUT_STAT_EN
    ,
    .lookup_count(lookup_count)
`endif
  );

  function automatic logic [7:0] lut_entry(input int a);
    return (a < 8) ? 8'(a * 16) : 8'd0;
  endfunction

  always_comb begin
    lut_base = lut_entry(int'(lut_address));
    lut_next = (lut_address == 4'd7) ? lut_entry(7) : lut_entry((int'(lut_address) + 1) % 16);
  end

  int total = 0;
  int bad   = 0;
  int exp_data[$];
  int exp_id[$];
  int exp_grant[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every grant and every result handshake is checked against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_ready != 4'b0) begin
        int g;
        g = 0;
        for (int i = 0; i < 4; i++)
          if (bus.req_ready[i]) g = i;
        chk("ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
        if (exp_grant.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_grant: got %0d expected none", g);
        end else
          chk("grant_id", g, exp_grant.pop_front());
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_data.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got %0d id %0d expected none", bus.res_data, bus.res_id);
        end else begin
          chk("res_data", 32'(bus.res_data), exp_data.pop_front());
          chk("res_id", 32'(bus.res_id), exp_id.pop_front());
        end
      end
    end
  end

  task automatic send(input int id, input logic [7:0] x, input int res);
    int n;
    @(posedge clk); #1;
    bus.req_data[8*id +: 8] = x;
    bus.req_valid[id] = 1'b1;
    exp_grant.push_back(id);
    exp_data.push_back(res);
    exp_id.push_back(id);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready[id] && n < 20);
    if (!bus.req_ready[id]) begin
      total++; bad++;
      $display("FAIL grant_timeout: got no ready expected ready[%0d]", id);
    end
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    @(negedge clk);
    chk("lut_address", 32'(lut_address), 32'(x[7:4]));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_data.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_data.size(), 0);
  endtask

  initial begin
    int cnt;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b1;
    #2;
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_lut_address", 32'(lut_address), 0);
    chk("rst_res_data", 32'(bus.res_data), 0);
    chk("rst_res_id", 32'(bus.res_id), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(1, 8'h25, 37);  drain();
    send(0, 8'h7F, 112); drain();
    send(3, 8'hF8, 0);   drain();
    send(2, 8'h00, 0);   drain();
    send(2, 8'h6A, 106); drain();

    // Backpressure: five stalled cycles, handshake on the sixth.
    bus.res_ready = 1'b0;
    send(0, 8'h1F, 31);
    cnt = 0;
    while (!bus.res_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("bp_valid_seen", 32'(bus.res_valid), 1);
    #1 bus.req_data = 32'h6A1F7F25;
    bus.req_valid = 4'b0110;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.res_valid), 1);
      chk("bp_data", 32'(bus.res_data), 31);
      chk("bp_id", 32'(bus.res_id), 0);
      chk("bp_req_ready", 32'(bus.req_ready), 0);
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_valid", 32'(bus.res_valid), 0);
    chk("bp_drained", exp_data.size(), 0);

    // Reset while requester 2's value is in LOOKUP.
    @(posedge clk); #1;
    bus.req_data[23:16] = 8'h25;
    bus.req_valid[2] = 1'b1;
    exp_grant.push_back(2);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.req_ready[2] && cnt < 20);
    @(posedge clk); #1;
    bus.req_valid = '0;
    rst = 1'b1;
    #1;
    chk("rstl_res_valid", 32'(bus.res_valid), 0);
    chk("rstl_req_ready", 32'(bus.req_ready), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstl_no_grant_left", exp_grant.size(), 0);

    // All four valid: order 0,1,2,3,0,1 from a fresh last_grant.
    exp_grant = '{0, 1, 2, 3, 0, 1};
    exp_data  = '{37, 112, 31, 106, 37, 112};
    exp_id    = '{0, 1, 2, 3, 0, 1};
    @(posedge clk); #1;
    bus.req_data  = 32'h6A1F7F25;
    bus.req_valid = 4'b1111;
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 6; c++) begin
      @(negedge clk);
      if (bus.req_ready != 4'b0) cnt++;
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk("all_valid_grants", cnt, 6);
    drain();
    repeat (4) @(negedge clk);

`ifdef ACT_LUT_STAT_EN
    chk("lookup_count", 32'(lookup_count), 6);
`endif
    chk("leftover", exp_data.size() + exp_grant.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
